mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port (F stage) and data port (M stage) for a unified-memory MIPS core.
- Sequences each access as a held request/completion transaction and generates fetch and memory-stage stall signals for the hazard unit.
- Data port has fixed priority: it belongs to the older instruction, so stalling it would deadlock the pipeline.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- i_req  in  1  fetch request; held high until i_valid.
- i_addr  in  AW  fetch address (PCF).
- i_rdata  out  DW  fetched instruction; valid only while i_valid=1.
- i_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address (ALUResultM).
- d_wdata  in  DW  store data (WriteDataM).
- d_rdata  out  DW  load data; valid only while d_valid=1.
- d_valid  out  1  one-cycle completion pulse for data.
- stall_f  out  1  i_req & ~i_valid (combinational).
- stall_m  out  1  d_req & ~d_valid (combinational).
- mem_req  out  1  memory request; held until mem_done.
- mem_we  out  1  write enable for the current transaction.
- mem_addr  out  AW  address for the current transaction.
- mem_wdata  out  DW  write data for the current transaction.
- mem_done  in  1  completion pulse, at least one cycle after mem_req rises; mem_rdata is valid in this cycle.
- mem_rdata  in  DW  read data.

Behaviour:
- FSM states:
  - IDLE (00): no transaction outstanding.
  - I_BUSY (01): fetch transaction in flight.
  - D_BUSY (10): data transaction in flight.
- IDLE transitions:
  - d_req=1 -> D_BUSY. Latch d_we, d_addr, d_wdata into the mem_* registers; mem_req=1 from the next cycle.
  - else i_req=1 -> I_BUSY. Latch i_addr, force mem_we=0.
  - both asserted -> D wins; the fetch waits.
- BUSY states:
  - mem_* outputs are stable registered values, independent of requester inputs.
  - On mem_done: pulse the owner's valid for exactly that cycle, drive its rdata combinationally from mem_rdata, drop mem_req, return to IDLE.
- Minimum transaction is 3 cycles (grant edge, >=1 wait, done cycle), followed by one mandatory IDLE cycle. Back-to-back grants are not permitted. This prevents re-granting a requester whose req is still high in its own valid cycle.
- Stores also complete on mem_done. d_valid pulses; d_rdata is don't-care.
- Requester drops req mid-transaction: the transaction still completes and valid still pulses. The requester ignores it.
- i_valid and d_valid are never high in the same cycle.
- Reset active (rst=0) at a clock edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_valid=0, d_valid=0, i_rdata/d_rdata=0 gated. This holds mid-transaction. The memory aborts on mem_req falling, and a mem_done arriving in IDLE is ignored.
- mem_done while IDLE: ignored, no valid pulse.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined: three extra 32-bit outputs, all cleared by reset and wrapping at 2^32:
  - perf_i_wait: counts cycles with stall_f=1.
  - perf_d_wait: counts cycles with stall_m=1.
  - perf_conflict: counts IDLE cycles with i_req & d_req.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - state encodings IDLE/I_BUSY/D_BUSY;
  - owner codes OWN_I=0, OWN_D=1;
  - default AW/DW.
- Optional sub-module mem_arb_perf: the three saturating-free counters, instantiated only under the macro.

Test Plan:
- Fetch only: i_req=1, i_addr=0x00400000, mem_done 2 cycles after mem_req with rdata=0x8C080004 -> mem_addr=0x00400000, mem_we=0; i_valid one cycle with i_rdata=0x8C080004; stall_f high until then.
- Simultaneous: i_req=d_req=1 in IDLE, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF -> D granted first. mem_we=1, mem_wdata=0xDEADBEEF. d_valid pulses, then one IDLE cycle, then fetch is granted.
- Load with latency 5: d_we=0, mem_done 5 cycles after grant, mem_rdata=0x12345678 -> mem_addr stable throughout; d_valid one cycle with 0x12345678; stall_m high for exactly the preceding cycles.
- Reset mid-transaction: assert rst=0 during D_BUSY -> next edge mem_req=0, state IDLE, no d_valid. A late mem_done is ignored.
- Input churn: change d_addr every cycle during D_BUSY and drop d_req before mem_done -> mem_addr holds the grant-time value; d_valid still pulses once.
- With MEM_PORT_ARBITER_PERF_EN, run the simultaneous scenario -> perf_conflict=1; perf_i_wait and perf_d_wait equal the cycle counts of stall_f and stall_m.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// requester owner codes and default bus widths.
package mem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Only meaningful in a busy state; IDLE maps to OWN_I but is masked by the caller.
    function automatic owner_t owner_of(arb_state_t s);
        return (s == D_BUSY) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (fetch/data) and memory-side signal bundle for mem_port_arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_valid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;

    logic          stall_f;
    logic          stall_m;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_done, mem_rdata,
        output i_rdata, i_valid, d_rdata, d_valid, stall_f, stall_m,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_done, mem_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid, stall_f, stall_m,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_perf.sv
// Wrapping stall/conflict event counters for the port arbiter.
// Compiled only when MEM_PORT_ARBITER_PERF_EN is defined.
`ifdef MEM_PORT_ARBITER_PERF_EN
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_f,
    input  logic        i_stall_m,
    input  logic        i_conflict,
    output logic [31:0] o_i_wait,
    output logic [31:0] o_d_wait,
    output logic [31:0] o_conflict
);

    logic [31:0] r_i_wait;
    logic [31:0] r_d_wait;
    logic [31:0] r_conflict;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i_wait   <= '0;
            r_d_wait   <= '0;
            r_conflict <= '0;
        end else begin
            if (i_stall_f)  r_i_wait   <= r_i_wait + 32'd1;
            if (i_stall_m)  r_d_wait   <= r_d_wait + 32'd1;
            if (i_conflict) r_conflict <= r_conflict + 32'd1;
        end
    end

    assign o_i_wait   = r_i_wait;
    assign o_d_wait   = r_d_wait;
    assign o_conflict = r_conflict;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports, data first.
// Optional perf counters are enabled with MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]          perf_i_wait,
    output logic [31:0]          perf_d_wait,
    output logic [31:0]          perf_conflict
`endif
);

    arb_state_t    r_state;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic w_busy;
    logic w_fire;
    logic w_i_valid;
    logic w_d_valid;
    logic w_stall_f;
    logic w_stall_m;

    // Valid is masked by reset so a done coinciding with reset never completes.
    assign w_busy    = (r_state == I_BUSY) || (r_state == D_BUSY);
    assign w_fire    = rst && w_busy && bus.mem_done;
    assign w_i_valid = w_fire && (owner_of(r_state) == OWN_I);
    assign w_d_valid = w_fire && (owner_of(r_state) == OWN_D);
    assign w_stall_f = bus.i_req && !w_i_valid;
    assign w_stall_m = bus.d_req && !w_d_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.d_req) begin
                        r_state     <= D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                    end else if (bus.i_req) begin
                        r_state    <= I_BUSY;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.i_addr;
                    end
                end
                // Completion always returns to IDLE, which enforces the idle gap.
                I_BUSY, D_BUSY: begin
                    if (bus.mem_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign bus.i_valid = w_i_valid;
    assign bus.d_valid = w_d_valid;
    assign bus.i_rdata = w_i_valid ? bus.mem_rdata : '0;
    assign bus.d_rdata = w_d_valid ? bus.mem_rdata : '0;
    assign bus.stall_f = w_stall_f;
    assign bus.stall_m = w_stall_m;

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic w_conflict;

    assign w_conflict = (r_state == IDLE) && bus.i_req && bus.d_req;

    mem_arb_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .i_stall_f  (w_stall_f),
        .i_stall_m  (w_stall_m),
        .i_conflict (w_conflict),
        .o_i_wait   (perf_i_wait),
        .o_d_wait   (perf_d_wait),
        .o_conflict (perf_conflict)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level requester/memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] perf_i_wait, perf_d_wait, perf_conflict;
`endif

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_i_wait   (perf_i_wait),
        .perf_d_wait   (perf_d_wait),
        .perf_conflict (perf_conflict)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] model_read(logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hC3C3_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        // Requests and a stray done while reset is held must not start anything.
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.mem_done = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0)
            begin bad++; $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h want 0/0/0/0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        total++;
        if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0)
            begin bad++; $display("FAIL reset_valid got iv=%b dv=%b ird=%h drd=%h want 0", bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata); end
        total++;
        if (bus.stall_f !== 1'b1 || bus.stall_m !== 1'b1)
            begin bad++; $display("FAIL reset_stall got f=%b m=%b want 1/1", bus.stall_f, bus.stall_m); end
        do_reset();
    endtask

    task automatic test_fetch_only();
        do_reset();
        tick();
        bus.i_req = 1'b1; bus.i_addr = 32'h0040_0000;
        @(negedge clk);
        total++;
        if (bus.stall_f !== 1'b1 || bus.mem_req !== 1'b0)
            begin bad++; $display("FAIL fetch_c0 got stall_f=%b mem_req=%b want 1/0", bus.stall_f, bus.mem_req); end
        tick();
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0040_0000 || bus.mem_we !== 1'b0 || bus.stall_f !== 1'b1)
            begin bad++; $display("FAIL fetch_grant got req=%b addr=%h we=%b stall=%b want 1/00400000/0/1", bus.mem_req, bus.mem_addr, bus.mem_we, bus.stall_f); end
        tick();
        @(negedge clk);
        total++;
        if (bus.i_valid !== 1'b0 || bus.stall_f !== 1'b1)
            begin bad++; $display("FAIL fetch_wait got valid=%b stall=%b want 0/1", bus.i_valid, bus.stall_f); end
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h8C08_0004;
        @(negedge clk);
        total++;
        if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h8C08_0004 || bus.stall_f !== 1'b0 || bus.d_valid !== 1'b0)
            begin bad++; $display("FAIL fetch_done got valid=%b rdata=%h stall=%b dv=%b want 1/8c080004/0/0", bus.i_valid, bus.i_rdata, bus.stall_f, bus.d_valid); end
        tick();
        bus.mem_done = 1'b0; bus.i_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.i_valid !== 1'b0 || bus.mem_req !== 1'b0)
            begin bad++; $display("FAIL fetch_after got valid=%b mem_req=%b want 0/0", bus.i_valid, bus.mem_req); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        bus.i_req = 1'b1; bus.i_addr = 32'h0040_0010;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++;
        if (bus.stall_f !== 1'b1 || bus.stall_m !== 1'b1 || bus.mem_req !== 1'b0)
            begin bad++; $display("FAIL sim_c0 got f=%b m=%b req=%b want 1/1/0", bus.stall_f, bus.stall_m, bus.mem_req); end
        tick();
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h1001_0000 || bus.mem_wdata !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL sim_dgrant got req=%b we=%b addr=%h wdata=%h want 1/1/10010000/deadbeef", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        tick();
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        total++;
        if (bus.d_valid !== 1'b1 || bus.i_valid !== 1'b0 || bus.stall_m !== 1'b0 || bus.stall_f !== 1'b1)
            begin bad++; $display("FAIL sim_ddone got dv=%b iv=%b m=%b f=%b want 1/0/0/1", bus.d_valid, bus.i_valid, bus.stall_m, bus.stall_f); end
        tick();
        bus.mem_done = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b0 || bus.stall_f !== 1'b1)
            begin bad++; $display("FAIL sim_idlegap got req=%b f=%b want 0/1", bus.mem_req, bus.stall_f); end
        tick();
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0040_0010)
            begin bad++; $display("FAIL sim_igrant got req=%b we=%b addr=%h want 1/0/00400010", bus.mem_req, bus.mem_we, bus.mem_addr); end
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h2402_0001;
        @(negedge clk);
        total++;
        if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h2402_0001 || bus.d_valid !== 1'b0)
            begin bad++; $display("FAIL sim_idone got iv=%b rdata=%h dv=%b want 1/24020001/0", bus.i_valid, bus.i_rdata, bus.d_valid); end
        tick();
        bus.mem_done = 1'b0; bus.i_req = 1'b0;
        @(negedge clk);
`ifdef MEM_PORT_ARBITER_PERF_EN
        // stall_f high c0..c5, stall_m high c0..c2, one IDLE cycle with both requests.
        total++;
        if (perf_i_wait !== 32'd6 || perf_d_wait !== 32'd3 || perf_conflict !== 32'd1)
            begin bad++; $display("FAIL sim_perf got i=%0d d=%0d c=%0d want 6/3/1", perf_i_wait, perf_d_wait, perf_conflict); end
`endif
        total++;
        if (bus.mem_req !== 1'b0 || bus.i_valid !== 1'b0)
            begin bad++; $display("FAIL sim_end got req=%b iv=%b want 0/0", bus.mem_req, bus.i_valid); end
    endtask

    task automatic test_load_lat5();
        int stalls;
        int bad_hold;
        do_reset();
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0040;
        @(negedge clk);
        stalls = (bus.stall_m === 1'b1) ? 1 : 0;
        bad_hold = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            @(negedge clk);
            if (bus.stall_m === 1'b1) stalls++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1001_0040 || bus.mem_we !== 1'b0 || bus.d_valid !== 1'b0)
                bad_hold++;
        end
        total++;
        if (bad_hold != 0)
            begin bad++; $display("FAIL lat5_hold got bad_cycles=%0d want 0", bad_hold); end
        tick();
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        total++;
        if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1234_5678 || bus.stall_m !== 1'b0)
            begin bad++; $display("FAIL lat5_done got dv=%b rdata=%h m=%b want 1/12345678/0", bus.d_valid, bus.d_rdata, bus.stall_m); end
        total++;
        if (stalls != 6)
            begin bad++; $display("FAIL lat5_stalls got %0d want 6", stalls); end
        tick();
        bus.mem_done = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0)
            begin bad++; $display("FAIL lat5_after got dv=%b req=%b want 0/0", bus.d_valid, bus.mem_req); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0080; bus.d_wdata = 32'hCAFE_F00D;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.d_valid !== 1'b0 || bus.mem_req !== 1'b1)
            begin bad++; $display("FAIL rstmid_pre got dv=%b req=%b want 0/1", bus.d_valid, bus.mem_req); end
        tick();
        rst = 1'b1;
        bus.d_req = 1'b0;
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b0 || bus.d_valid !== 1'b0 || bus.i_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0)
            begin bad++; $display("FAIL rstmid_post got req=%b dv=%b iv=%b addr=%h we=%b want 0/0/0/0/0", bus.mem_req, bus.d_valid, bus.i_valid, bus.mem_addr, bus.mem_we); end
        tick();
        bus.mem_done = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_req !== 1'b0 || bus.d_valid !== 1'b0)
            begin bad++; $display("FAIL rstmid_idle got req=%b dv=%b want 0/0", bus.mem_req, bus.d_valid); end
    endtask

    task automatic test_churn();
        int bad_hold;
        int pulses;
        do_reset();
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0010; bus.d_wdata = 32'h0;
        bad_hold = 0;
        pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_we    = 1'($urandom_range(0, 1));
            if (c >= 2) bus.d_req = 1'b0;
            bus.mem_done  = (c == 4);
            bus.mem_rdata = 32'h0BAD_F00D;
            @(negedge clk);
            if (bus.d_valid === 1'b1) pulses++;
            if (c <= 4 && (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1001_0010 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0))
                bad_hold++;
            if (c == 5 && bus.mem_req !== 1'b0) bad_hold++;
        end
        bus.mem_done = 1'b0;
        total++;
        if (bad_hold != 0)
            begin bad++; $display("FAIL churn_hold got bad_cycles=%0d want 0", bad_hold); end
        total++;
        if (pulses != 1)
            begin bad++; $display("FAIL churn_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_random();
        bit          i_pend = 0, d_pend = 0, dwe = 0;
        logic [31:0] ia = '0, da = '0, dw = '0, rd_next = '0;
        bit          prev_i = 0, prev_d = 0, prev_mreq = 0, prev_valid = 0;
        bit          done_next = 0, done_now, own_d = 0;
        int          lat = 1, since = 0, comp_i = 0, comp_d = 0;
        do_reset();
        mem_model.delete();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            tick();
            done_now      = done_next;
            bus.mem_done  = done_now;
            bus.mem_rdata = done_now ? rd_next : $urandom;
            if (!i_pend && cyc < 2000 && $urandom_range(0, 2) != 0) begin
                i_pend = 1; ia = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            end
            if (!d_pend && cyc < 2000 && $urandom_range(0, 3) == 0) begin
                d_pend = 1; dwe = 1'($urandom_range(0, 1));
                da = 32'h1001_0000 + 32'($urandom_range(0, 7)) * 4; dw = $urandom;
            end
            bus.i_req = i_pend; bus.i_addr = ia;
            bus.d_req = d_pend; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dw;
            @(negedge clk);
            total++;
            if (bus.i_valid === 1'b1 && bus.d_valid === 1'b1)
                begin bad++; $display("FAIL rnd_both_valid cyc=%0d got 1/1 want not both", cyc); end
            total++;
            if (bus.stall_f !== (i_pend && !bus.i_valid) || bus.stall_m !== (d_pend && !bus.d_valid))
                begin bad++; $display("FAIL rnd_stall cyc=%0d got f=%b m=%b want %b/%b", cyc, bus.stall_f, bus.stall_m, i_pend && !bus.i_valid, d_pend && !bus.d_valid); end
            total++;
            if ((bus.i_valid === 1'b1 || bus.d_valid === 1'b1) != done_now)
                begin bad++; $display("FAIL rnd_valid cyc=%0d got iv=%b dv=%b want done=%b", cyc, bus.i_valid, bus.d_valid, done_now); end
            if (prev_valid) begin
                total++;
                if (bus.mem_req !== 1'b0)
                    begin bad++; $display("FAIL rnd_idle_gap cyc=%0d got mem_req=%b want 0", cyc, bus.mem_req); end
            end
            if (bus.mem_req === 1'b1 && !prev_mreq) begin
                own_d = prev_d;
                lat = $urandom_range(1, 4); since = 0;
                total++;
                if (!(prev_i || prev_d))
                    begin bad++; $display("FAIL rnd_spurious_grant cyc=%0d got mem_req=1 want 0", cyc); end
                else if (own_d && (bus.mem_addr !== da || bus.mem_we !== dwe || (dwe && bus.mem_wdata !== dw)))
                    begin bad++; $display("FAIL rnd_dgrant cyc=%0d got addr=%h we=%b wd=%h want %h/%b/%h", cyc, bus.mem_addr, bus.mem_we, bus.mem_wdata, da, dwe, dw); end
                else if (!own_d && (bus.mem_addr !== ia || bus.mem_we !== 1'b0))
                    begin bad++; $display("FAIL rnd_igrant cyc=%0d got addr=%h we=%b want %h/0", cyc, bus.mem_addr, bus.mem_we, ia); end
            end
            prev_i = i_pend; prev_d = d_pend;
            if (bus.i_valid === 1'b1) begin
                total++;
                if (!i_pend || own_d || bus.i_rdata !== rd_next)
                    begin bad++; $display("FAIL rnd_fetch cyc=%0d got rdata=%h own_d=%b want %h", cyc, bus.i_rdata, own_d, rd_next); end
                i_pend = 0; comp_i++;
            end
            if (bus.d_valid === 1'b1) begin
                total++;
                if (!d_pend || !own_d || (!dwe && bus.d_rdata !== rd_next))
                    begin bad++; $display("FAIL rnd_data cyc=%0d got rdata=%h own_d=%b want %h", cyc, bus.d_rdata, own_d, rd_next); end
                d_pend = 0; comp_d++;
            end
            if (done_now && own_d && dwe) mem_model[da] = dw;
            done_next = 0;
            if (bus.mem_req === 1'b1 && !done_now) begin
                since++;
                if (since == lat) begin
                    done_next = 1;
                    rd_next = own_d ? model_read(da) : model_read(ia);
                end
            end
            prev_mreq  = (bus.mem_req === 1'b1);
            prev_valid = (bus.i_valid === 1'b1) || (bus.d_valid === 1'b1);
        end
        total++;
        if (i_pend || d_pend)
            begin bad++; $display("FAIL rnd_drain got i_pend=%b d_pend=%b want 0/0", i_pend, d_pend); end
        total++;
        if (comp_i < 50 || comp_d < 20)
            begin bad++; $display("FAIL rnd_activity got fetch=%0d data=%0d want >=50/>=20", comp_i, comp_d); end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_load_lat5();
        test_reset_mid();
        test_churn();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
